// File: rtl/key_sw_device.sv
// Memory-mapped key/switch device with per-group debounce, Ready/Overrun/IE status and interrupt.
// Latency: loads combinational from ABUS; raw input to update = 2 sync edges + DEBOUNCE_CYCLES+1 edges.
// Backpressure: none; every load/store completes in the cycle it is presented.
//
// Ports:
//   clk      - sole clock, rising edge
//   RESET_N  - asynchronous active-low reset
//   ABUS     - byte address from the MEM stage
//   DIN      - store data
//   WE / RE  - store / load strobes
//   KEY      - raw keys, active-low, asynchronous
//   SW       - raw switches, active-high, asynchronous
//   DOUT     - load data (0 when the address is not ours)
//   SEL      - high when ABUS matches one of the four registers
//   INTR     - (KIE & KReady) | (SIE & SReady)
module key_sw_device #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDRKDATA       = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSDATA       = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hFFFFF094,
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ABUS,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    input  logic             RE,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    output logic             INTR
);

    // Group 0 = keys, group 1 = switches. Both groups share a 10-bit datapath;
    // the key group simply never sees anything above bit 3.
    localparam int NG = 2;
    localparam int GW = 10;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Control register bit positions
    localparam int B_READY = 0;
    localparam int B_OVR   = 2;
    localparam int B_IE    = 8;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NG-1:0] hit_data;
    logic [NG-1:0] hit_ctrl;
    logic [NG-1:0] rd_clr;    // load of a DATA register clears its Ready
    logic [NG-1:0] ctrl_wr;   // store to a CTRL register

    assign hit_data = {ABUS == ADDRSDATA, ABUS == ADDRKDATA};
    assign hit_ctrl = {ABUS == ADDRSCTRL, ABUS == ADDRKCTRL};
    assign rd_clr   = hit_data & {NG{RE}};
    assign ctrl_wr  = hit_ctrl & {NG{WE}};
    assign SEL      = |{hit_data, hit_ctrl};

    // Keys are active-low: invert before synchronizing so the idle level
    // matches the all-zero reset state of the pipeline.
    logic [GW-1:0] raw [NG];
    assign raw[0] = {6'b0, ~KEY};
    assign raw[1] = SW;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GW-1:0] sync1_q [NG];
    logic [GW-1:0] sync1_d [NG];
    logic [GW-1:0] sync2_q [NG];
    logic [GW-1:0] sync2_d [NG];
    logic [GW-1:0] cand_q  [NG];
    logic [GW-1:0] cand_d  [NG];
    logic [CW-1:0] cnt_q   [NG];
    logic [CW-1:0] cnt_d   [NG];
    logic [GW-1:0] data_q  [NG];
    logic [GW-1:0] data_d  [NG];
    logic [NG-1:0] ready_q, ready_d;
    logic [NG-1:0] ovr_q,   ovr_d;
    logic [NG-1:0] ie_q,    ie_d;
    logic [NG-1:0] update;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        update  = '0;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        for (int g = 0; g < NG; g++) begin
            sync1_d[g] = raw[g];
            sync2_d[g] = sync1_q[g];
            cand_d[g]  = cand_q[g];
            cnt_d[g]   = cnt_q[g];
            data_d[g]  = data_q[g];

            // Candidate/counter debouncer: any change restarts the count,
            // a stable candidate counts up and parks at CNT_MAX.
            if (sync2_q[g] != cand_q[g]) begin
                cand_d[g] = sync2_q[g];
                cnt_d[g]  = '0;
            end else if (cnt_q[g] != CNT_MAX) begin
                cnt_d[g] = cnt_q[g] + CW'(1);
            end

            // Accept only once the count has saturated, the input still
            // agrees, and the value is actually new.
            update[g] = (cnt_q[g] == CNT_MAX) && (sync2_q[g] == cand_q[g])
                        && (cand_q[g] != data_q[g]);
            if (update[g]) begin
                data_d[g] = cand_q[g];
            end

            // Overrun flags an update that lands on unread data. An update
            // that coincides with a DATA load or CTRL store does not raise it.
            if (update[g] && ready_q[g] && !rd_clr[g] && !ctrl_wr[g]) begin
                ovr_d[g] = 1'b1;
            end else if (ctrl_wr[g] && !DIN[B_OVR]) begin
                ovr_d[g] = 1'b0;
            end

            // Set wins over the clear from a DATA load.
            if (update[g]) begin
                ready_d[g] = 1'b1;
            end else if (rd_clr[g]) begin
                ready_d[g] = 1'b0;
            end

            if (ctrl_wr[g]) begin
                ie_d[g] = DIN[B_IE];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int g = 0; g < NG; g++) begin
                sync1_q[g] <= '0;
                sync2_q[g] <= '0;
                cand_q[g]  <= '0;
                cnt_q[g]   <= '0;
                data_q[g]  <= '0;
            end
            ready_q <= '0;
            ovr_q   <= '0;
            ie_q    <= '0;
        end else begin
            for (int g = 0; g < NG; g++) begin
                sync1_q[g] <= sync1_d[g];
                sync2_q[g] <= sync2_d[g];
                cand_q[g]  <= cand_d[g];
                cnt_q[g]   <= cnt_d[g];
                data_q[g]  <= data_d[g];
            end
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

    // ------------------------------------------------------------------
    // Load data mux (purely a function of ABUS and register state)
    // ------------------------------------------------------------------
    always_comb begin
        DOUT = '0;
        for (int g = 0; g < NG; g++) begin
            if (hit_data[g]) begin
                DOUT[GW-1:0] = data_q[g];
            end
            if (hit_ctrl[g]) begin
                DOUT[B_READY] = ready_q[g];
                DOUT[B_OVR]   = ovr_q[g];
                DOUT[B_IE]    = ie_q[g];
            end
        end
    end

    assign INTR = |(ie_q & ready_q);

endmodule

// File: tb/tb_key_sw_device.sv
module tb_key_sw_device;

    localparam int N = 4;
    localparam logic [31:0] KD = 32'hFFFFF080;
    localparam logic [31:0] KC = 32'hFFFFF084;
    localparam logic [31:0] SD = 32'hFFFFF090;
    localparam logic [31:0] SC = 32'hFFFFF094;
    localparam logic [31:0] ADDRS [4] = '{KD, KC, SD, SC};

    logic        clk = 1'b0;
    logic        RESET_N;
    logic [31:0] ABUS, DIN;
    logic        WE, RE;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] DOUT;
    logic        SEL, INTR;

    always #10 clk = ~clk;

    key_sw_device #(
        .DBITS(32), .ADDRKDATA(KD), .ADDRKCTRL(KC),
        .ADDRSDATA(SD), .ADDRSCTRL(SC), .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .ABUS(ABUS), .DIN(DIN), .WE(WE), .RE(RE),
        .KEY(KEY), .SW(SW), .DOUT(DOUT), .SEL(SEL), .INTR(INTR)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each group remembers the raw values it sampled on
    // past edges (index 0 = most recent). A new value is accepted on an edge
    // once the N+1 samples taken 2..N+2 edges earlier all agree on it.
    logic [9:0] m_data [2];
    bit         m_rdy  [2];
    bit         m_ovr  [2];
    bit         m_ie   [2];
    logic [9:0] hist   [2][N+2];

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_data[g] = '0; m_rdy[g] = 0; m_ovr[g] = 0; m_ie[g] = 0;
            for (int i = 0; i < N + 2; i++) hist[g][i] = '0;
        end
    endtask

    task automatic model_edge();
        logic [9:0]  smp [2];
        logic [31:0] da, ca;
        bit stable, upd, rd, wr;
        if (RESET_N !== 1'b1) return;
        smp[0] = {6'b0, ~KEY};
        smp[1] = SW;
        for (int g = 0; g < 2; g++) begin
            da = (g == 0) ? KD : SD;
            ca = (g == 0) ? KC : SC;
            stable = 1;
            for (int i = 2; i <= N + 1; i++)
                if (hist[g][i] !== hist[g][1]) stable = 0;
            upd = stable && (hist[g][1] != m_data[g]);
            rd  = RE && (ABUS == da);
            wr  = WE && (ABUS == ca);
            if (upd && m_rdy[g] && !rd && !wr) m_ovr[g] = 1;
            else if (wr && !DIN[2])            m_ovr[g] = 0;
            if (upd)     m_rdy[g] = 1;
            else if (rd) m_rdy[g] = 0;
            if (wr)  m_ie[g] = DIN[8];
            if (upd) m_data[g] = hist[g][1];
            for (int i = N + 1; i > 0; i--) hist[g][i] = hist[g][i-1];
            hist[g][0] = smp[g];
        end
    endtask

    function automatic logic [31:0] m_ctrl(int g);
        return (32'(m_ie[g]) << 8) | (32'(m_ovr[g]) << 2) | 32'(m_rdy[g]);
    endfunction

    function automatic logic [31:0] mread(logic [31:0] a);
        if (a == KD) return {28'b0, m_data[0][3:0]};
        if (a == KC) return m_ctrl(0);
        if (a == SD) return {22'b0, m_data[1]};
        if (a == SC) return m_ctrl(1);
        return 32'h0;
    endfunction

    function automatic logic mintr();
        return (m_ie[0] && m_rdy[0]) || (m_ie[1] && m_rdy[1]);
    endfunction

    function automatic logic msel(logic [31:0] a);
        return (a == KD) || (a == KC) || (a == SD) || (a == SC);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge; inputs are sampled by model and DUT alike, then we
    // park on the falling edge where outputs are stable.
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic rd_chk(string tag, logic [31:0] a, logic [31:0] exp);
        ABUS = a;
        #1;
        chk(tag, DOUT, exp);
    endtask

    // Sweep all four registers against the model, then INTR.
    task automatic chk_regs(string tag);
        logic [31:0] save;
        save = ABUS;
        for (int i = 0; i < 4; i++) begin
            ABUS = ADDRS[i];
            #1;
            chk($sformatf("%s_dout%0d", tag, i), DOUT, mread(ADDRS[i]));
            chk($sformatf("%s_sel%0d", tag, i), 32'(SEL), 32'h1);
        end
        ABUS = save;
        #1;
        chk({tag, "_intr"}, 32'(INTR), 32'(mintr()));
    endtask

    initial begin
        int r;
        RESET_N = 1'b0; ABUS = '0; DIN = '0; WE = 0; RE = 0; KEY = 4'hF; SW = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk_regs("reset");
        rd_chk("reset_kdata", KD, 0);
        chk("reset_intr", 32'(INTR), 0);
        ABUS = 32'h1234_0000;
        #1;
        chk("unmapped_sel", 32'(SEL), 0);
        chk("unmapped_dout", DOUT, 0);

        RESET_N = 1'b1;
        cyc(3);
        chk_regs("idle");

        // Press: key 0 down and held
        KEY = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            chk_regs($sformatf("press_e%0d", e));
            if (e == 5) rd_chk("press_not_before_6", KC, 0);
        end
        rd_chk("press_kdata", KD, 1);
        rd_chk("press_kctrl", KC, 1);

        // Loading CTRL has no side effect; loading DATA clears Ready
        ABUS = KC; RE = 1;
        cyc(1);
        RE = 0;
        rd_chk("ctrl_load_no_side", KC, 1);
        ABUS = KD; RE = 1;
        #1;
        chk("rd_dout_same_cycle", DOUT, 1);
        cyc(1);
        RE = 0;
        rd_chk("clr_on_read", KC, 0);
        chk_regs("after_clr");

        // Bounce: toggle every 2 cycles for 20 cycles
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) KEY = (KEY == 4'hF) ? 4'hE : 4'hF;
            cyc(1);
            rd_chk("bounce_kctrl", KC, 0);
        end
        cyc(4);
        chk_regs("after_bounce");

        // Release and consume
        KEY = 4'hF;
        cyc(8);
        rd_chk("release_kdata", KD, 0);
        rd_chk("release_kctrl", KC, 1);
        ABUS = KD; RE = 1;
        cyc(1);
        RE = 0;

        // Overrun on switches, then clear it by storing 0
        SW = 10'h001;
        cyc(8);
        SW = 10'h003;
        cyc(8);
        rd_chk("ovr_sctrl", SC, 32'h5);
        rd_chk("ovr_sdata", SD, 32'h3);
        ABUS = SC; DIN = 32'h0; WE = 1;
        cyc(1);
        WE = 0;
        rd_chk("ovr_clr", SC, 32'h1);
        chk_regs("ovr");
        ABUS = SD; RE = 1;
        cyc(1);
        RE = 0;

        // IE set, then update coinciding with a KDATA load
        ABUS = KC; DIN = 32'h100; WE = 1;
        cyc(1);
        WE = 0; DIN = 0;
        rd_chk("ie_set", KC, 32'h100);
        chk("ie_intr_idle", 32'(INTR), 0);
        KEY = 4'hE;
        cyc(6);
        ABUS = KD; RE = 1;
        cyc(1);
        RE = 0;
        rd_chk("sim_kctrl", KC, 32'h101);
        rd_chk("sim_kdata", KD, 32'h1);
        chk("sim_intr", 32'(INTR), 1);
        chk_regs("sim");

        // Reset in the middle of a switch debounce
        SW = 10'h200;
        cyc(5);
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk_regs("midreset");
        chk("midreset_intr", 32'(INTR), 0);
        cyc(2);
        RESET_N = 1'b1;
        cyc(6);
        rd_chk("rst_sdata_early", SD, 32'h0);
        cyc(1);
        rd_chk("rst_sdata", SD, 32'h200);
        rd_chk("rst_sctrl", SC, 32'h1);
        chk_regs("postreset");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) KEY = 4'($urandom);
            if ($urandom_range(0, 7) == 0) SW  = 10'($urandom);
            r = $urandom_range(0, 5);
            ABUS = (r < 4) ? ADDRS[r] : $urandom;
            RE  = ($urandom_range(0, 3) == 0);
            WE  = ($urandom_range(0, 5) == 0);
            DIN = $urandom;
            #1;
            chk("rnd_dout", DOUT, mread(ABUS));
            chk("rnd_sel", 32'(SEL), 32'(msel(ABUS)));
            chk("rnd_intr", 32'(INTR), 32'(mintr()));
            cyc(1);
        end
        RE = 0; WE = 0;
        chk_regs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sw_device.md
KEY_SW_DEVICE -- requirements
Module: key_sw_device

Interface
REQ-001 SHALL provide parameter DBITS, default 32, meaning bus data/address width.
REQ-002 SHALL provide parameter ADDRKDATA, default 32'hFFFFF080, meaning key data register address.
REQ-003 SHALL provide parameter ADDRKCTRL, default 32'hFFFFF084, meaning key control/status register address.
REQ-004 SHALL provide parameter ADDRSDATA, default 32'hFFFFF090, meaning switch data register address.
REQ-005 SHALL provide parameter ADDRSCTRL, default 32'hFFFFF094, meaning switch control/status register address.
REQ-006 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, meaning clocks an input must stay stable before it is accepted.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port ABUS, input, DBITS, byte address from the MEM stage.
REQ-010 SHALL have port DIN, input, DBITS, store data.
REQ-011 SHALL have port WE, input, 1, store strobe.
REQ-012 SHALL have port RE, input, 1, load strobe.
REQ-013 SHALL have port KEY, input, 4, raw keys, active-low.
REQ-014 SHALL have port SW, input, 10, raw switches, active-high.
REQ-015 SHALL have port DOUT, output, DBITS, load data.
REQ-016 SHALL have port SEL, output, 1, high when ABUS equals any of the four register addresses.
REQ-017 SHALL have port INTR, output, 1, interrupt request.

Function
REQ-018 SHALL drive DOUT and SEL combinationally from ABUS in the same cycle, with no dependence on RE; DOUT is 0 when SEL=0.
REQ-019 SHALL keep KDATA[3:0] = debounced ~KEY and SDATA[9:0] = debounced SW, with upper bits reading 0.
REQ-020 SHALL define CTRL layout, identical for KCTRL and SCTRL: bit0 Ready (read-only to stores), bit2 Overrun, bit8 IE; all other bits read 0.
REQ-021 SHALL debounce each group independently with a candidate register and a counter:
- raw differs from candidate: load candidate, clear counter.
- otherwise: increment counter, saturating at DEBOUNCE_CYCLES-1.
REQ-022 SHALL load DATA from the candidate on the edge where counter = DEBOUNCE_CYCLES-1, raw = candidate and candidate != DATA; that event is an "update".
REQ-023 SHALL set Ready on an update; if Ready was already 1 and is not cleared that cycle, SHALL also set Overrun.
REQ-024 SHALL clear Ready on a rising edge where RE=1 and ABUS=the group's DATA address.
REQ-025 SHALL, on a rising edge where WE=1 and ABUS=CTRL, load IE from DIN[8]; DIN[2]=0 clears Overrun, DIN[2]=1 leaves it unchanged; DIN[0] is ignored.
REQ-026 SHALL give set priority over clear: an update coinciding with a DATA read or a CTRL write leaves Ready=1 and Overrun unset by that update.
REQ-027 SHALL ignore stores to DATA addresses and loads of CTRL addresses, which have no side effects.
REQ-028 SHALL drive INTR = (KIE & KReady) | (SIE & SReady) from registers, with no combinational path from inputs.
REQ-029 SHALL accept raw KEY/SW asynchronously through a 2-flop synchronizer ahead of the debouncer, adding 2 cycles of latency.
REQ-030 SHALL produce an update no earlier than DEBOUNCE_CYCLES+2 edges after a stable raw change.

Reset
REQ-031 SHALL asynchronously clear, while RESET_N=0, all DATA, candidate, synchronizer, counter, Ready, Overrun and IE state, so that INTR=0 and DOUT for every address reads 0.
REQ-032 SHALL, after reset, treat a nonzero debounced input like any other change, producing an update and setting Ready.
REQ-033 SHALL abandon any in-progress debounce when reset is asserted mid-count, without producing an update.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Press: KEY 4'hF->4'hE held → KDATA=1 and KCTRL=1 by edge 7, not before edge 6.
REQ-035 Bounce: KEY toggles every 2 cycles for 20 cycles → no update; KCTRL=0 throughout.
REQ-036 Clear-on-read: Ready=1, RE=1 at ADDRKDATA → DOUT=1 that cycle, KCTRL=0 next cycle; RE=1 at ADDRKCTRL → no change.
REQ-037 Overrun: SW=0x001 stable, then SW=0x003 stable, no reads → SCTRL=0x5; store 0 to ADDRSCTRL → SCTRL=0x1.
REQ-038 IE/simultaneous: store 0x100 to ADDRKCTRL, then an update coincides with a KDATA read → Ready=1, INTR=1, Overrun=0.
REQ-039 Reset mid-count: drop RESET_N at count 2 → all reads 0 and INTR=0; with SW=0x200 held after release → SDATA=0x200 and Ready=1.
